// File: rtl/key_recorder.sv
// Records keypad notes into a small buffer while rec is high and replays them,
// one note per NOTE_TICKS clocks, on a play request.
module key_recorder #(
  parameter int DEPTH      = 16,
  parameter int NOTE_TICKS = 10000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pressed,
  input  logic [3:0]               key,
  input  logic                     rec,
  input  logic                     play,
  output logic [3:0]               value,
  output logic                     playing,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(NOTE_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(NOTE_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

  state_t         state, state_next;
  logic           press_s1, press_sync, press_d;
  logic           play_s1, play_sync, play_d;
  logic [AW-1:0]  rptr;
  logic [TW-1:0]  tick;
  logic [3:0]     note;
  logic [3:0]     mem [DEPTH];

  logic           press_edge, play_edge, last_tick, last_slot;
  logic           wr_en, entering_record, start_play, advance, rd_en;
  logic [AW-1:0]  rd_addr;
  logic [AW:0]    last_idx;

  assign press_edge = press_sync & ~press_d;
  assign play_edge  = play_sync & ~play_d;
  assign full       = (count == (AW+1)'(DEPTH));
  assign last_idx   = count - 1'b1;
  assign last_tick  = (tick == TICK_LAST);
  assign last_slot  = ({1'b0, rptr} == last_idx);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rec) state_next = RECORD;
               else if (play_edge && count != '0) state_next = PLAY;
      RECORD:  if (!rec) state_next = IDLE;
      PLAY:    if (rec) state_next = RECORD;
               else if (last_tick && last_slot) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rec always forces RECORD from IDLE or PLAY, so any entry clears the buffer
  assign entering_record = rec && (state != RECORD);
  assign wr_en           = (state == RECORD) && rec && press_edge && !full;
  assign start_play      = (state == IDLE) && (state_next == PLAY);
  assign advance         = (state == PLAY) && !rec && last_tick && !last_slot;
  assign rd_en           = start_play | advance;
  assign rd_addr         = start_play ? '0 : rptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      press_s1   <= 1'b0;
      press_sync <= 1'b0;
      press_d    <= 1'b0;
      play_s1    <= 1'b0;
      play_sync  <= 1'b0;
      play_d     <= 1'b0;
      count      <= '0;
      rptr       <= '0;
      tick       <= '0;
      playing    <= 1'b0;
    end else begin
      state      <= state_next;
      press_s1   <= pressed;
      press_sync <= press_s1;
      press_d    <= press_sync;
      play_s1    <= play;
      play_sync  <= play_s1;
      play_d     <= play_sync;
      playing    <= (state_next == PLAY);

      if (entering_record) count <= '0;
      else if (wr_en)      count <= count + 1'b1;

      if (start_play) begin
        rptr <= '0;
        tick <= '0;
      end else if (state == PLAY) begin
        if (last_tick) begin
          tick <= '0;
          if (advance) rptr <= rptr + 1'b1;
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

  // Buffer is not reset; reads are registered into note ahead of each slot
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= key;
    if (rd_en) note <= mem[rd_addr];
  end

  assign value = (state == PLAY) ? note : (press_sync ? key : 4'hF);

endmodule

// File: tb/tb_key_recorder.sv
// Randomized bench for key_recorder: a queue of recorded notes predicts
// what playback must show, note by note.
module tb_key_recorder;

  localparam int DEPTH = 4;
  localparam int NT    = 4;

  logic       clk = 1'b0;
  logic       rst_n, pressed, rec, play;
  logic [3:0] key, value;
  logic       playing, full;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] model_q[$];

  key_recorder #(.DEPTH(DEPTH), .NOTE_TICKS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .pressed(pressed), .key(key), .rec(rec),
    .play(play), .value(value), .playing(playing), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] k);
    key = k;
    pressed = 1'b1;
    cycles(4);
    n_checks++;
    if (value !== k) begin
      n_fail++;
      $display("FAIL press_value: value=%h expected %h", value, k);
    end
    pressed = 1'b0;
    cycles(3);
    if (rec && model_q.size() < DEPTH) model_q.push_back(k);
    $display("press key=%h count=%0d", k, count);
  endtask

  task automatic start_rec();
    rec = 1'b1;
    model_q.delete();
    cycles(2);
  endtask

  task automatic stop_rec();
    rec = 1'b0;
    cycles(2);
  endtask

  task automatic check_count(input string name);
    n_checks++;
    if (count !== 3'(model_q.size()) ||
        full !== (model_q.size() == DEPTH)) begin
      n_fail++;
      $display("FAIL %s: count=%0d full=%b expected count=%0d full=%b", name,
               count, full, model_q.size(), model_q.size() == DEPTH);
    end
  endtask

  // Raise play and wait (bounded) for the first PLAY cycle.
  task automatic start_play(input string name, output bit ok);
    int waited = 0;
    play = 1'b1;
    while (playing !== 1'b1 && waited < 12) begin
      cycles(1);
      waited++;
      if (waited == 3) play = 1'b0;
    end
    play = 1'b0;
    n_checks++;
    ok = (playing === 1'b1);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_start: playing=%b expected 1 within 12 cycles", name, playing);
    end
  endtask

  task automatic play_and_check(input string name);
    bit ok;
    start_play(name, ok);
    if (!ok) begin
      cycles(20);
      return;
    end
    foreach (model_q[i]) begin
      for (int t = 0; t < NT; t++) begin
        n_checks++;
        if (value !== model_q[i] || playing !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_note%0d_t%0d: value=%h playing=%b expected %h 1",
                   name, i, t, value, playing, model_q[i]);
        end
        cycles(1);
      end
      $display("play %s note %0d = %h", name, i, model_q[i]);
    end
    n_checks++;
    if (playing !== 1'b0 || value !== 4'hF) begin
      n_fail++;
      $display("FAIL %s_end: playing=%b value=%h expected 0 F", name, playing, value);
    end
    check_count({name, "_count"});
  endtask

  task automatic expect_no_play(input string name);
    bit seen = 0;
    play = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycles(1);
      if (c == 3) play = 1'b0;
      if (playing !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL %s: playing went high, expected to stay 0", name);
    end
    $display("no-play %s count=%0d", name, count);
  endtask

  task automatic test_reset();
    n_checks++;
    if (playing !== 1'b0 || count !== 3'd0 || full !== 1'b0 || value !== 4'hF) begin
      n_fail++;
      $display("FAIL reset: playing=%b count=%0d full=%b value=%h expected 0 0 0 F",
               playing, count, full, value);
    end
    $display("reset checked");
  endtask

  task automatic test_record_basic();
    start_rec();
    press_key(4'h3);
    press_key(4'h7);
    press_key(4'h1);
    stop_rec();
    check_count("record_basic_count");
    n_checks++;
    if (value !== 4'hF) begin
      n_fail++;
      $display("FAIL rest_value: value=%h expected F", value);
    end
  endtask

  task automatic test_overflow();
    start_rec();
    for (int k = 10; k < 15; k++) press_key(4'(k));
    stop_rec();
    check_count("overflow_count");
    play_and_check("overflow");
  endtask

  task automatic test_empty_play();
    start_rec();
    stop_rec();
    check_count("empty_count");
    expect_no_play("empty");
  endtask

  task automatic test_play_in_record();
    start_rec();
    press_key(4'h9);
    expect_no_play("in_record");
    stop_rec();
    check_count("in_record_count");
  endtask

  task automatic test_abort();
    bit ok;
    start_rec();
    press_key(4'h2);
    press_key(4'h4);
    press_key(4'h6);
    stop_rec();
    start_play("abort", ok);
    if (ok) begin
      cycles(NT + 1);
      n_checks++;
      if (value !== model_q[1]) begin
        n_fail++;
        $display("FAIL abort_note2: value=%h expected %h", value, model_q[1]);
      end
      rec = 1'b1;
      model_q.delete();
      cycles(1);
      n_checks++;
      if (playing !== 1'b0 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL abort: playing=%b count=%0d expected 0 0", playing, count);
      end
    end
    $display("abort count=%0d", count);
    stop_rec();
  endtask

  task automatic test_reset_mid_play();
    bit ok;
    start_rec();
    press_key(4'h8);
    press_key(4'h5);
    stop_rec();
    start_play("rst_mid", ok);
    cycles(5);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    n_checks++;
    if (playing !== 1'b0 || count !== 3'd0 || value !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_mid_play: playing=%b count=%0d value=%h expected 0 0 F",
               playing, count, value);
    end
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    expect_no_play("after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int n = $urandom_range(1, 6);
      start_rec();
      for (int j = 0; j < n; j++) press_key(4'($urandom_range(0, 15)));
      stop_rec();
      check_count("random_count");
      play_and_check("random");
    end
  endtask

  task automatic test_back_to_back();
    play_and_check("b2b_first");
    cycles(2);
    play_and_check("b2b_second");
  endtask

  initial begin
    rst_n = 1'b0; pressed = 1'b0; key = 4'h0; rec = 1'b0; play = 1'b0;
    cycles(3);
    test_reset();
    rst_n = 1'b1;
    cycles(2);
    test_record_basic();
    play_and_check("basic");
    test_overflow();
    test_empty_play();
    test_play_in_record();
    test_abort();
    test_reset_mid_play();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
